pipe_stage_skid_reg: RTL and testbench

// Parametrised inter-stage pipeline register with a valid/ready handshake.

---
 rtl/pipe_stage_skid_reg.sv | 81 ++++++++
 tb/tb_pipe_stage_skid_reg.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid_reg.sv
// Inter-stage pipeline register with valid/ready handshake and a 2-entry skid buffer.
// in_ready depends on registered state only, so back-pressure never forms a combinational chain.
module pipe_stage_skid_reg #(
    parameter int unsigned     WIDTH     = 32,
    parameter logic [WIDTH-1:0] CTRL_MASK = '0,
    parameter int unsigned     CNT_W     = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_count
);

    logic             r_main_v;
    logic [WIDTH-1:0] r_main_d;
    logic             r_skid_v;
    logic [WIDTH-1:0] r_skid_d;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_in_accept;
    logic w_out_fire;
    logic w_main_free;
    logic w_stalled;

    always_comb begin
        in_ready    = ~r_skid_v;
        out_valid   = r_main_v;
        // Bubbles must never present asserted control bits downstream.
        out_data    = r_main_v ? r_main_d : (r_main_d & ~CTRL_MASK);
        stall_count = r_stall_cnt;
        w_in_accept = in_valid & ~r_skid_v & ~flush;
        w_out_fire  = r_main_v & out_ready;
        w_main_free = ~r_main_v | w_out_fire;
        w_stalled   = r_main_v & ~out_ready;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_main_v    <= 1'b0;
            r_main_d    <= '0;
            r_skid_v    <= 1'b0;
            r_skid_d    <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_stalled && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end

            if (flush) begin
                // Data regs keep their contents; only the valid flags are squashed.
                r_main_v <= 1'b0;
                r_skid_v <= 1'b0;
            end else if (w_main_free) begin
                if (r_skid_v) begin
                    r_main_v <= 1'b1;
                    r_main_d <= r_skid_d;
                    if (w_in_accept) begin
                        r_skid_d <= in_data;
                    end else begin
                        r_skid_v <= 1'b0;
                    end
                end else if (w_in_accept) begin
                    r_main_v <= 1'b1;
                    r_main_d <= in_data;
                end else begin
                    r_main_v <= 1'b0;
                end
            end else if (w_in_accept) begin
                r_skid_v <= 1'b1;
                r_skid_d <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed bench for pipe_stage_skid_reg: one wide instance with masked control bits and
// one instance with a 3-bit stall counter for saturation.
module tb_pipe_stage_skid_reg;

    logic        Clk;
    logic        Rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [15:0] stall_count;

    logic        b_rst;
    logic        b_flush;
    logic        b_in_valid;
    logic        b_in_ready;
    logic [7:0]  b_in_data;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [7:0]  b_out_data;
    logic [2:0]  b_stall_count;

    int n_cmp = 0;
    int n_err = 0;

    pipe_stage_skid_reg #(
        .WIDTH    (32),
        .CTRL_MASK(32'h3),
        .CNT_W    (16)
    ) u_dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .stall_count(stall_count)
    );

    pipe_stage_skid_reg #(
        .WIDTH    (8),
        .CTRL_MASK(8'h0),
        .CNT_W    (3)
    ) u_dut_sat (
        .Clk        (Clk),
        .Rst        (b_rst),
        .flush      (b_flush),
        .in_valid   (b_in_valid),
        .in_ready   (b_in_ready),
        .in_data    (b_in_data),
        .out_valid  (b_out_valid),
        .out_ready  (b_out_ready),
        .out_data   (b_out_data),
        .stall_count(b_stall_count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        Rst        = 1'b1;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        b_rst      = 1'b1;
        b_flush    = 1'b0;
        b_in_valid = 1'b0;
        b_in_data  = '0;
        b_out_ready = 1'b0;
        step();
        Rst   = 1'b0;
        b_rst = 1'b0;

        // Reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_data", out_data, 0);
        chk("rst_stall", stall_count, 0);

        // Back-to-back streaming
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h11;
        step();
        chk("s1_valid", out_valid, 1);
        chk("s1_data", out_data, 32'h11);
        in_data = 32'h22;
        step();
        chk("s2_valid", out_valid, 1);
        chk("s2_data", out_data, 32'h22);
        in_data = 32'h33;
        step();
        chk("s3_valid", out_valid, 1);
        chk("s3_data", out_data, 32'h33);
        in_valid = 1'b0;
        step();
        chk("s_drain_valid", out_valid, 0);
        chk("s_bubble_mask", out_data, 32'h30);
        chk("s_stall", stall_count, 0);

        // Back-pressure fills main then skid
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        step();
        chk("bp_a_data", out_data, 32'hA);
        chk("bp_a_ready", in_ready, 1);
        in_data = 32'hB;
        step();
        chk("bp_b_ready", in_ready, 0);
        chk("bp_b_hold", out_data, 32'hA);
        chk("bp_b_stall", stall_count, 1);
        in_data = 32'hC;
        step();
        chk("bp_c_ready", in_ready, 0);
        chk("bp_c_hold", out_data, 32'hA);
        chk("bp_c_stall", stall_count, 2);
        out_ready = 1'b1;
        step();
        chk("rel_b_valid", out_valid, 1);
        chk("rel_b_data", out_data, 32'hB);
        chk("rel_b_ready", in_ready, 1);
        step();
        chk("rel_c_valid", out_valid, 1);
        chk("rel_c_data", out_data, 32'hC);
        in_valid = 1'b0;
        step();
        chk("rel_end_valid", out_valid, 0);
        chk("rel_stall", stall_count, 2);

        // Flush squashes the held beat and the beat offered alongside it
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hFF;
        step();
        chk("fl_load", out_data, 32'hFF);
        flush   = 1'b1;
        in_data = 32'h55;
        step();
        chk("fl_valid", out_valid, 0);
        chk("fl_mask", out_data, 32'hFC);
        chk("fl_ready", in_ready, 1);
        chk("fl_stall", stall_count, 3);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("fl_no55_valid", out_valid, 0);
        chk("fl_no55_data", out_data, 32'hFC);

        // Reset with both entries full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h66;
        step();
        in_data = 32'h77;
        step();
        chk("full_ready", in_ready, 0);
        chk("full_data", out_data, 32'h66);
        chk("full_stall", stall_count, 4);
        Rst     = 1'b1;
        in_data = 32'h88;
        step();
        Rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("mrst_valid", out_valid, 0);
        chk("mrst_ready", in_ready, 1);
        chk("mrst_stall", stall_count, 0);
        chk("mrst_data", out_data, 0);
        step();
        chk("mrst_no_old", out_valid, 0);

        // Stall counter saturation on the 3-bit instance
        b_in_valid = 1'b1;
        b_in_data  = 8'h5A;
        step();
        b_in_valid = 1'b0;
        chk("sat_load", b_out_data, 8'h5A);
        chk("sat_start", b_stall_count, 0);
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 5) chk("sat_5", b_stall_count, 5);
        end
        chk("sat_10", b_stall_count, 7);
        chk("sat_hold_data", b_out_data, 8'h5A);
        chk("sat_hold_valid", b_out_valid, 1);
        b_out_ready = 1'b1;
        step();
        chk("sat_drained", b_out_valid, 0);
        chk("sat_kept", b_stall_count, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
